// File: rtl/sd_spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sd_spi_pkg                                         |
// | Description : Shared types and constants for the SD-card SPI     |
// |               responder (idle byte, bit counter width, states).  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package sd_spi_pkg;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;
  localparam int         BIT_CNT_W         = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 3'd7;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // MSB-first shift: drop bit 7, append the new bit at bit 0.
  function automatic logic [7:0] shl_in(input logic [7:0] v, input logic b);
    return {v[6:0], b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sync_edge                                          |
// | Description : N-stage synchronizer for an asynchronous level,    |
// |               with single-cycle rise/fall pulses derived from    |
// |               the synchronized value.                            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              lvl;

  assign lvl = sync_q[STAGES-1];

  // Shift the raw input through the chain; remember last synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= lvl;
    end
  end

  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule
`default_nettype wire

// File: rtl/sd_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sd_spi_responder                                   |
// | Description : SPI mode-0 byte responder for an SD-card style     |
// |               bus, oversampled on clkin_50. One-entry TX buffer, |
// |               valid/ready RX byte output.                        |
// | Options     : define SD_SPI_RESP_OVR_EN to build the sticky RX   |
// |               overrun flag (otherwise overrun is tied 0).        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
  input  logic       clkin_50,
  input  logic       rst_n,
  input  logic       sd_clk,
  input  logic       sd_cmd,
  input  logic       sd_dat3,
  output logic       sd_dat0,
  output logic       sd_dat0_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  input  logic       ovr_clr
);

  // ---------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] cmd_sync_q;
  logic cmd_s;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clkin_50), .rst_n(rst_n), .d_i(sd_clk),
    .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clkin_50), .rst_n(rst_n), .d_i(sd_dat3),
    .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // MOSI only needs its level; it is stable around every sampled SCLK rise.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) cmd_sync_q <= {SYNC_STAGES{1'b1}};
    else        cmd_sync_q <= (cmd_sync_q << 1) | SYNC_STAGES'(sd_cmd);
  end
  assign cmd_s = cmd_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  state_e               state_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [7:0]           tx_shift_q, rx_shift_q;
  logic                 oe_q;
  logic [7:0]           txbuf_q;
  logic                 txbuf_full_q;
  logic [7:0]           rx_data_q;
  logic                 rx_valid_q;

  // Per-cycle events
  logic       frame_start, frame_end, bit_rise, bit_fall;
  logic       tx_reload, byte_done, tx_wr, rx_take;
  logic [7:0] reload_byte, rx_byte;

  // Decode synchronized SPI events; a CS rise pre-empts any same-cycle SCLK edge.
  always_comb begin
    frame_start = (state_q == IDLE) && cs_fall;
    frame_end   = (state_q == ACTIVE) && cs_rise;
    bit_rise    = (state_q == ACTIVE) && !cs_rise && sclk_rise;
    bit_fall    = (state_q == ACTIVE) && !cs_rise && sclk_fall;
    tx_reload   = frame_start || (bit_fall && (bit_cnt_q == '0));
    reload_byte = txbuf_full_q ? txbuf_q : IDLE_BYTE;
    rx_byte     = shl_in(rx_shift_q, cmd_s);
    byte_done   = bit_rise && (bit_cnt_q == BIT_CNT_LAST);
    tx_wr       = tx_valid && !txbuf_full_q;
    rx_take     = rx_valid_q && rx_ready;
  end

  // Frame FSM with bit counter and both shift registers.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      oe_q       <= 1'b0;
      bit_cnt_q  <= '0;
      tx_shift_q <= IDLE_BYTE;
      rx_shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q   <= ACTIVE;
            oe_q      <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        ACTIVE: begin
          if (frame_end) begin
            // Partial RX bits are abandoned; the next byte starts fresh.
            state_q    <= IDLE;
            oe_q       <= 1'b0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
          end else if (bit_rise) begin
            rx_shift_q <= rx_byte;
            bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
          end else if (bit_fall && (bit_cnt_q != '0)) begin
            tx_shift_q <= shl_in(tx_shift_q, 1'b1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (tx_reload) tx_shift_q <= reload_byte;
    end
  end

  // One-entry TX buffer; a reload samples the buffer before a same-cycle write.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      txbuf_q      <= '0;
      txbuf_full_q <= 1'b0;
    end else if (tx_wr) begin
      txbuf_q      <= tx_data;
      txbuf_full_q <= 1'b1;
    end else if (tx_reload && txbuf_full_q) begin
      txbuf_full_q <= 1'b0;
    end
  end

  // RX holding register; a freshly completed byte always wins over a dequeue.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (byte_done) begin
      rx_data_q  <= rx_byte;
      rx_valid_q <= 1'b1;
    end else if (rx_take) begin
      rx_valid_q <= 1'b0;
    end
  end

`ifdef SD_SPI_RESP_OVR_EN
  logic overrun_q;

  // Sticky overrun: set when a byte lands on an un-taken one; set beats clear.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n)                                      overrun_q <= 1'b0;
    else if (byte_done && rx_valid_q && !rx_ready)   overrun_q <= 1'b1;
    else if (ovr_clr)                                overrun_q <= 1'b0;
  end
  assign overrun = overrun_q;
`else
  logic ovr_clr_unused;
  assign ovr_clr_unused = ovr_clr;
  assign overrun        = 1'b0;
`endif

  assign sd_dat0    = tx_shift_q[7];
  assign sd_dat0_oe = oe_q;
  assign tx_ready   = !txbuf_full_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_sd_spi_responder                                |
// | Description : Self-checking bench for sd_spi_responder: vector   |
// |               table, directed corner sequences, and random       |
// |               frames against a byte-level reference model.       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_sd_spi_responder;

  localparam int SYNC = 2;
  localparam int HALF = 8;   // clkin_50 cycles per SCLK half period
`ifdef SD_SPI_RESP_OVR_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sd_clk = 1'b0, sd_cmd = 1'b1, sd_dat3 = 1'b1;
  logic       sd_dat0, sd_dat0_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b0;
  logic       overrun, ovr_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  sd_spi_responder #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .clkin_50(clk), .rst_n(rst_n),
    .sd_clk(sd_clk), .sd_cmd(sd_cmd), .sd_dat3(sd_dat3),
    .sd_dat0(sd_dat0), .sd_dat0_oe(sd_dat0_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    sd_dat3 = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    sd_dat3 = 1'b1;
    tick(HALF);
  endtask

  // Master side of mode 0: MOSI set while SCLK low, MISO sampled before the rise.
  task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sd_cmd = mosi[i];
      tick(HALF);
      miso[i] = sd_dat0;
      sd_clk = 1'b1;
      tick(HALF);
      sd_clk = 1'b0;
    end
  endtask

  task automatic tx_write(input logic [7:0] v);
    tx_data = v; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic rx_deq();
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(1);
  endtask

  task automatic clr_ovr();
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0; tick(1);
  endtask

  // ---------------- reference model: TX buffer as seen by the master ----------
  logic [7:0] pend;
  logic       pend_v = 1'b0;

  // Every byte boundary (CS fall and each completed byte) takes the pending
  // byte if there is one, otherwise the idle pattern.
  function automatic logic [7:0] model_reload();
    if (pend_v) begin
      pend_v = 1'b0;
      return pend;
    end
    return 8'hFF;
  endfunction

  typedef struct {
    logic       pre_wr;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] got, got2, exp_b, mosi_b;
    logic [7:0] mosi_q[$];
    int nb;
    logic pre_wr, mid_wr;

    tbl[0] = '{pre_wr:1'b0, tx:8'h00, mosi:8'hA5, exp_miso:8'hFF, exp_rx:8'hA5};
    tbl[1] = '{pre_wr:1'b1, tx:8'h3C, mosi:8'h00, exp_miso:8'h3C, exp_rx:8'h00};
    tbl[2] = '{pre_wr:1'b1, tx:8'h80, mosi:8'hFF, exp_miso:8'h80, exp_rx:8'hFF};
    tbl[3] = '{pre_wr:1'b0, tx:8'h00, mosi:8'h5A, exp_miso:8'hFF, exp_rx:8'h5A};
    tbl[4] = '{pre_wr:1'b1, tx:8'h01, mosi:8'hC3, exp_miso:8'h01, exp_rx:8'hC3};

    // ---- reset state ----
    tick(3);
    check("rst_dat0", {31'b0, sd_dat0}, 1);
    check("rst_oe", {31'b0, sd_dat0_oe}, 0);
    check("rst_tx_ready", {31'b0, tx_ready}, 1);
    check("rst_rx_valid", {31'b0, rx_valid}, 0);
    check("rst_rx_data", {24'b0, rx_data}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    rst_n = 1'b1;
    tick(4);

    // ---- single-byte frames from the table ----
    for (int v = 0; v < 5; v++) begin
      if (tbl[v].pre_wr) begin
        tx_write(tbl[v].tx);
        check("tbl_tx_ready_full", {31'b0, tx_ready}, 0);
      end
      check("tbl_oe_idle", {31'b0, sd_dat0_oe}, 0);
      cs_low();
      check("tbl_oe_active", {31'b0, sd_dat0_oe}, 1);
      check("tbl_tx_ready_csfall", {31'b0, tx_ready}, 1);
      xfer(tbl[v].mosi, 8, got);
      cs_high();
      check("tbl_miso", {24'b0, got}, {24'b0, tbl[v].exp_miso});
      check("tbl_rx_data", {24'b0, rx_data}, {24'b0, tbl[v].exp_rx});
      check("tbl_rx_valid", {31'b0, rx_valid}, 1);
      rx_deq();
      check("tbl_rx_deq", {31'b0, rx_valid}, 0);
    end

    // ---- preloaded byte then idle byte in a two-byte frame ----
    tx_write(8'h3C);
    check("b2_tx_ready_full", {31'b0, tx_ready}, 0);
    cs_low();
    check("b2_tx_ready_csfall", {31'b0, tx_ready}, 1);
    xfer(8'h12, 8, got);
    xfer(8'h34, 8, got2);
    cs_high();
    check("b2_miso0", {24'b0, got}, 32'h3C);
    check("b2_miso1", {24'b0, got2}, 32'hFF);
    check("b2_rx_data", {24'b0, rx_data}, 32'h34);
    rx_deq();
    clr_ovr();

    // ---- two bytes without dequeue: overwrite and overrun ----
    cs_low();
    xfer(8'h11, 8, got);
    xfer(8'h22, 8, got);
    cs_high();
    check("ovr_rx_data", {24'b0, rx_data}, 32'h22);
    check("ovr_rx_valid", {31'b0, rx_valid}, 1);
    check("ovr_flag", {31'b0, overrun}, {31'b0, OVR_ON});
    clr_ovr();
    check("ovr_clr", {31'b0, overrun}, 0);
    rx_deq();

    // ---- CS raised mid-byte, then a clean frame ----
    cs_low();
    xfer(8'hF0, 4, got);
    cs_high();
    check("abort_oe", {31'b0, sd_dat0_oe}, 0);
    check("abort_rx_valid", {31'b0, rx_valid}, 0);
    check("abort_rx_data", {24'b0, rx_data}, 32'h22);
    cs_low();
    xfer(8'h81, 8, got);
    cs_high();
    check("abort_next_rx", {24'b0, rx_data}, 32'h81);
    check("abort_next_valid", {31'b0, rx_valid}, 1);
    rx_deq();

    // ---- dequeue in the exact cycle a new byte completes ----
    cs_low();
    xfer(8'h44, 8, got);
    check("race_pend_data", {24'b0, rx_data}, 32'h44);
    check("race_pend_valid", {31'b0, rx_valid}, 1);
    xfer(8'h55, 7, got);
    sd_cmd = 1'b1;             // bit 0 of 0x55
    tick(HALF);
    sd_clk = 1'b1;
    tick(SYNC);                // the responder acts on the next rising clkin_50 edge
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(HALF - SYNC - 1);
    sd_clk = 1'b0;
    cs_high();
    check("race_rx_data", {24'b0, rx_data}, 32'h55);
    check("race_rx_valid", {31'b0, rx_valid}, 1);
    check("race_overrun", {31'b0, overrun}, 0);

    // ---- asynchronous reset mid-byte with a byte queued for TX ----
    cs_low();
    tx_write(8'h99);
    check("rst_mid_tx_ready", {31'b0, tx_ready}, 0);
    xfer(8'hF0, 4, got);
    rst_n = 1'b0;
    sd_dat3 = 1'b1;
    #1;
    check("rstmid_dat0", {31'b0, sd_dat0}, 1);
    check("rstmid_oe", {31'b0, sd_dat0_oe}, 0);
    check("rstmid_tx_ready", {31'b0, tx_ready}, 1);
    check("rstmid_rx_valid", {31'b0, rx_valid}, 0);
    check("rstmid_rx_data", {24'b0, rx_data}, 0);
    check("rstmid_overrun", {31'b0, overrun}, 0);
    pend_v = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    cs_low();
    xfer(8'hC3, 8, got);
    cs_high();
    check("rstmid_next_miso", {24'b0, got}, 32'hFF);
    check("rstmid_next_rx", {24'b0, rx_data}, 32'hC3);
    check("rstmid_next_valid", {31'b0, rx_valid}, 1);
    rx_deq();

    // ---- random frames against the model ----
    for (int f = 0; f < 30; f++) begin
      nb     = int'($urandom_range(1, 3));
      pre_wr = 1'($urandom_range(0, 1));
      mid_wr = 1'($urandom_range(0, 1));
      mosi_q.delete();
      if (pre_wr) begin
        exp_b = 8'($urandom);
        check("rnd_tx_ready_pre", {31'b0, tx_ready}, {31'b0, !pend_v});
        tx_write(exp_b);
        pend = exp_b; pend_v = 1'b1;
      end
      cs_low();
      exp_b = model_reload();
      if (mid_wr) begin
        got2 = 8'($urandom);
        tx_write(got2);
        pend = got2; pend_v = 1'b1;
      end
      for (int k = 0; k < nb; k++) begin
        mosi_b = 8'($urandom);
        mosi_q.push_back(mosi_b);
        xfer(mosi_b, 8, got);
        check("rnd_miso", {24'b0, got}, {24'b0, exp_b});
        exp_b = model_reload();
      end
      cs_high();
      check("rnd_rx_data", {24'b0, rx_data}, {24'b0, mosi_q[$]});
      check("rnd_rx_valid", {31'b0, rx_valid}, 1);
      check("rnd_overrun", {31'b0, overrun}, {31'b0, OVR_ON && (nb >= 2)});
      check("rnd_tx_ready", {31'b0, tx_ready}, {31'b0, !pend_v});
      rx_deq();
      clr_ovr();
      check("rnd_rx_deq", {31'b0, rx_valid}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sd_clk/sd_cmd/sd_dat3.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF, byte shifted out when no TX byte is pending.
REQ-003 clkin_50  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 sd_clk  in  1  SPI SCLK from master, asynchronous to clkin_50.
REQ-006 sd_cmd  in  1  MOSI.
REQ-007 sd_dat3  in  1  chip select, active-low.
REQ-008 sd_dat0  out  1  MISO data.
REQ-009 sd_dat0_oe  out  1  MISO output enable; high only while selected.
REQ-010 tx_data  in  8  next byte to send; tx_valid in 1; tx_ready out 1; valid/ready handshake.
REQ-011 rx_data  out  8  last received byte; rx_valid out 1; rx_ready in 1; valid/ready handshake.
REQ-012 overrun  out  1  sticky RX overrun flag; ovr_clr in 1 clears it.

Function
REQ-013 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes, sd_clk ≤ clkin_50/8.
REQ-014 SHALL pass sd_clk, sd_cmd, sd_dat3 through SYNC_STAGES flops; edges detected on synchronized values.
REQ-015 SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synchronized sd_dat3 falling; ACTIVE->IDLE on its rising.
REQ-016 On IDLE->ACTIVE: bit_cnt=0, tx_shift loaded from TX buffer if full (buffer emptied) else IDLE_BYTE.
REQ-017 sd_dat0 SHALL equal tx_shift[7]; sd_dat0_oe SHALL be 1 exactly in ACTIVE.
REQ-018 On sd_clk rising in ACTIVE: rx_shift <= {rx_shift[6:0], sd_cmd}; bit_cnt increments modulo 8.
REQ-019 On rising edge that wraps bit_cnt 7->0: rx_data <= completed byte, rx_valid <= 1 on the next clkin_50 cycle.
REQ-020 On sd_clk falling in ACTIVE: bit_cnt≠0 -> tx_shift shifts left by 1; bit_cnt==0 -> tx_shift reloads per REQ-016 rule.
REQ-021 TX buffer SHALL be one entry; tx_ready = buffer empty; tx_valid&&tx_ready writes it.
REQ-022 TX write and reload in same cycle: reload sees old (empty) buffer -> IDLE_BYTE; written byte kept for next reload.
REQ-023 rx_valid SHALL stay high until rx_valid&&rx_ready; then cleared unless a new byte completes same cycle (new byte wins, rx_valid stays 1, no overrun).
REQ-024 Byte completing while rx_valid=1 and rx_ready=0 SHALL overwrite rx_data.
REQ-025 CS deasserted mid-byte: partial RX bits discarded, bit_cnt=0, rx_valid/rx_data untouched, dequeued TX byte lost.
REQ-026 sd_clk edges while IDLE SHALL be ignored.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, bit_cnt 0, tx_shift IDLE_BYTE, sd_dat0 1, sd_dat0_oe 0, tx_ready 1 (buffer empty), rx_data 0, rx_valid 0, overrun 0, synchronizers to idle levels (sd_clk 0, sd_cmd 1, sd_dat3 1).
REQ-028 Reset mid-frame SHALL abandon the frame; after release, a new CS falling edge is required before any bit is shifted.

Configuration
REQ-029 Macro SD_SPI_RESP_OVR_EN defined: overrun set on every REQ-024 event, cleared by ovr_clr (set wins if simultaneous).
REQ-030 SD_SPI_RESP_OVR_EN undefined: overrun tied 0, ovr_clr ignored, no overrun logic synthesized.

Structure
REQ-031 Package sd_spi_pkg SHALL hold IDLE_BYTE default, bit-count width (3), state enum {IDLE, ACTIVE}.
REQ-032 Sub-module sync_edge (N-stage synchronizer plus rise/fall pulse outputs) SHALL be instantiated for sd_clk and sd_dat3; sd_cmd uses synchronizer path only.

Verification
REQ-033 Reset, no TX loaded, CS low, 8 clocks MOSI=0xA5 -> MISO 0xFF, rx_data=0xA5, rx_valid=1 after 8th edge.
REQ-034 tx_data=0x3C written before CS low, then 2 bytes clocked -> MISO 0x3C then 0xFF; tx_ready returns 1 at CS fall.
REQ-035 Two bytes 0x11, 0x22 received with rx_ready=0 -> rx_data=0x22, overrun=1 (macro on) / 0 (macro off); ovr_clr pulse -> 0.
REQ-036 CS raised after 4 clocks, new frame MOSI=0x81 -> rx_data=0x81, no partial byte delivered, sd_dat0_oe=0 between frames.
REQ-037 rx_ready=1 in the cycle byte 0x55 completes while 0x44 pending -> rx_data=0x55, rx_valid=1, overrun=0.
REQ-038 rst_n low mid-byte -> all outputs at REQ-027 values within one cycle; next full frame MOSI=0xC3 received correctly.
